traffic_light_monitor: RTL
==========================

# traffic_light_monitor

Observing-side counterpart of the traffic-light output decoder. It samples the six lamp lines (highway and farm-road red/yellow/green) and recovers the controller state, tagged valid or invalid, from the lamp pattern. It checks every state change against the legal S0→S1→S2→S3→S0 sequence and against minimum dwell times, and reports violations as sticky error flags. It sits beside the controller on the lamp bus and serves as a run-time safety checker and a bench scoreboard source.

## Interface
- MIN_GREEN, default 8: minimum cycles a green state (S0, S2) must be held.
- MIN_YELLOW, default 3: minimum cycles a yellow state (S1, S3) must be held.
- CNT_W, default 8: width of the dwell counter and the cycle counter.
- Clk_i  input  1  sole clock; all logic updates on its rising edge.
- nReset_i  input  1  reset, synchronous, active-low.
- HR_i, HY_i, HG_i, FR_i, FY_i, FG_i  input  1 each  sampled lamp lines.
- Clear_i  input  1  clears all sticky error flags.
- State_o  output  2  last valid decoded state (S0=00, S1=01, S2=10, S3=11).
- StateValid_o  output  1  the current sample is a legal pattern.
- DwellCnt_o  output  CNT_W  cycles the current state has been held; saturating.
- CycleCnt_o  output  CNT_W  completed S3→S0 transitions; wraps.
- IllegalPattern_o  output  1  sticky; a sample was not one of the four legal patterns.
- IllegalTrans_o  output  1  sticky; a valid-to-valid change was not to the successor state.
- ShortDwell_o  output  1  sticky; a state was exited before its minimum dwell.

## Operation
- Pattern decode, with {HR,HY,HG,FR,FY,FG}:
  - 001100 → S0
  - 010100 → S1
  - 100001 → S2
  - 100010 → S3
  - Any other value, including 000000, is illegal.
- The internal `armed` flag is cleared by reset and by any illegal sample. It is set by the first valid sample.
- Valid sample while not armed:
  - Load State_o with the decoded state and set DwellCnt_o=1.
  - Perform no transition or dwell checks.
- Valid sample equal to State_o while armed:
  - Increment DwellCnt_o, saturating at 2^CNT_W−1.
- Valid sample different from State_o while armed:
  - Set IllegalTrans_o if the new state is not State_o+1 mod 4.
  - Set ShortDwell_o if DwellCnt_o is below the minimum for the state being exited (MIN_GREEN for S0/S2, MIN_YELLOW for S1/S3).
  - Load the new state and set DwellCnt_o=1.
  - If the change is S3→S0, increment CycleCnt_o, wrapping.
- Illegal sample:
  - StateValid_o=0 and IllegalPattern_o set.
  - State_o and DwellCnt_o hold their values.
  - No dwell check is made for the state being exited.
- Clear_i clears the three sticky flags. If a new error is detected in the same cycle, set wins over clear. Clear_i does not affect counters or State_o.

## Timing
- All outputs are registered, with a latency of 1 cycle from a lamp sample to the corresponding output update.
- Reset values:
  - State_o=00, StateValid_o=0, DwellCnt_o=0, CycleCnt_o=0.
  - All error flags 0; `armed`=0.
- Reset asserted mid-sequence:
  - All state is reinitialised at the next edge.
  - The first valid sample after reset release is never flagged.
- Saturation: once DwellCnt_o is saturated it stays saturated until the state changes. A saturated count satisfies any minimum.
- A one-cycle glitch to a different legal state is treated as a real transition and checked; a glitch to an illegal pattern disarms the checker.

## Configuration
- TRAFFIC_MON_CYCLE_COUNT_EN:
  - Defined: the CycleCnt_o counter is implemented as described.
  - Undefined: no counter register is built; CycleCnt_o is tied to 0. Port list unchanged.

## Structure
- Package tl_pkg holds:
  - The state encodings S0..S3.
  - The four 6-bit lamp-pattern constants.
  - A next-state function (s+1 mod 4).
  - A function that returns the minimum dwell for a state.
- Sub-module traffic_light_decode: combinational lamp-pattern → {valid, state} decoder. It is reusable by the controller's own assertions.

## Test plan
- Reset, then drive S0×8, S1×3, S2×8, S3×3, S0 → no flags, CycleCnt_o=1, DwellCnt_o=1 after the final edge.
- S0×8 then S2 → IllegalTrans_o=1 one cycle later; State_o=10.
- S0×8 then S1×2 then S2 → ShortDwell_o=1; IllegalTrans_o=0.
- S0×5, then 111111, then S2 → IllegalPattern_o=1, StateValid_o=0 during the illegal sample, no IllegalTrans_o on S2, DwellCnt_o=1.
- Set ShortDwell_o, then pulse Clear_i in the same cycle as a new short-dwell exit → flag stays 1. Clear_i alone on the next cycle → 0.
- Hold S0 for 300 cycles with CNT_W=8 → DwellCnt_o=255, then S1 gives no ShortDwell_o. Assert nReset_i low mid-S1 → all outputs return to their reset values.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light lamp bus: the controller state
// encoding, the lamp pattern for each state, and small helpers used by the
// monitor and by anything else that needs to reason about the sequence.
package tl_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,  // highway green, farm road red
        S1 = 2'b01,  // highway yellow, farm road red
        S2 = 2'b10,  // highway red, farm road green
        S3 = 2'b11   // highway red, farm road yellow
    } tl_state_e;

    // Lamp patterns ordered {HR, HY, HG, FR, FY, FG}
    localparam logic [5:0] LAMP_S0 = 6'b001100;
    localparam logic [5:0] LAMP_S1 = 6'b010100;
    localparam logic [5:0] LAMP_S2 = 6'b100001;
    localparam logic [5:0] LAMP_S3 = 6'b100010;

    // Legal successor of a state in the S0->S1->S2->S3->S0 ring
    function automatic tl_state_e tl_next(input tl_state_e s);
        return tl_state_e'(s + 2'd1);
    endfunction

    // Minimum hold time of a state: greens use min_green, yellows min_yellow
    function automatic int tl_min_dwell(input tl_state_e s,
                                        input int min_green,
                                        input int min_yellow);
        return ((s == S0) || (s == S2)) ? min_green : min_yellow;
    endfunction

endpackage

// File: rtl/traffic_light_decode.sv
// Combinational lamp-pattern decoder: maps the six lamp lines onto a
// controller state and flags whether the pattern is one of the four legal ones.
module traffic_light_decode
    import tl_pkg::*;
(
    input  logic [5:0] lamps_i,   // {HR, HY, HG, FR, FY, FG}
    output logic       valid_o,
    output tl_state_e  state_o
);

    // Exact-match decode; anything else (including all-dark) is illegal
    always_comb begin
        valid_o = 1'b1;
        state_o = S0;
        case (lamps_i)
            LAMP_S0: state_o = S0;
            LAMP_S1: state_o = S1;
            LAMP_S2: state_o = S2;
            LAMP_S3: state_o = S3;
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Run-time checker for the traffic-light lamp bus. Recovers the controller
// state from the lamp lines, tracks dwell time, and raises sticky flags for
// illegal patterns, out-of-order transitions and states left too early.
// Optional feature: define TRAFFIC_MON_CYCLE_COUNT_EN to build the counter of
// completed S3->S0 rounds; otherwise CycleCnt_o is tied to zero.
module traffic_light_monitor
    import tl_pkg::*;
#(
    parameter int MIN_GREEN  = 8,
    parameter int MIN_YELLOW = 3,
    parameter int CNT_W      = 8
) (
    input  logic             Clk_i,
    input  logic             nReset_i,
    input  logic             HR_i,
    input  logic             HY_i,
    input  logic             HG_i,
    input  logic             FR_i,
    input  logic             FY_i,
    input  logic             FG_i,
    input  logic             Clear_i,
    output logic [1:0]       State_o,
    output logic             StateValid_o,
    output logic [CNT_W-1:0] DwellCnt_o,
    output logic [CNT_W-1:0] CycleCnt_o,
    output logic             IllegalPattern_o,
    output logic             IllegalTrans_o,
    output logic             ShortDwell_o
);

    localparam logic [CNT_W-1:0] DWELL_MAX = '1;
    localparam logic [CNT_W-1:0] DWELL_ONE = CNT_W'(1);

    logic       dec_valid;
    tl_state_e  dec_state;

    tl_state_e        state_d,  state_q;
    logic             valid_d,  valid_q;
    logic [CNT_W-1:0] dwell_d,  dwell_q;
    logic             armed_d,  armed_q;
    logic             ipat_d,   ipat_q;
    logic             itrans_d, itrans_q;
    logic             short_d,  short_q;

    logic set_ipat, set_itrans, set_short;

    traffic_light_decode u_decode (
        .lamps_i ({HR_i, HY_i, HG_i, FR_i, FY_i, FG_i}),
        .valid_o (dec_valid),
        .state_o (dec_state)
    );

    // Tracking and checking: arm on the first legal sample, then check each change
    always_comb begin
        state_d    = state_q;
        dwell_d    = dwell_q;
        armed_d    = armed_q;
        valid_d    = dec_valid;
        set_ipat   = 1'b0;
        set_itrans = 1'b0;
        set_short  = 1'b0;

        if (!dec_valid) begin
            // Illegal sample: keep state/dwell, drop arming so nothing is judged
            set_ipat = 1'b1;
            armed_d  = 1'b0;
        end else if (!armed_q) begin
            state_d = dec_state;
            dwell_d = DWELL_ONE;
            armed_d = 1'b1;
        end else if (dec_state == state_q) begin
            if (dwell_q != DWELL_MAX) begin
                dwell_d = dwell_q + DWELL_ONE;
            end
        end else begin
            set_itrans = (dec_state != tl_next(state_q));
            // A saturated count meets any minimum, even one above the counter range
            set_short  = (dwell_q != DWELL_MAX) &&
                         (int'(dwell_q) < tl_min_dwell(state_q, MIN_GREEN, MIN_YELLOW));
            state_d    = dec_state;
            dwell_d    = DWELL_ONE;
        end

        // Sticky flags: a fresh detection beats a simultaneous clear
        ipat_d   = set_ipat   | (ipat_q   & ~Clear_i);
        itrans_d = set_itrans | (itrans_q & ~Clear_i);
        short_d  = set_short  | (short_q  & ~Clear_i);
    end

    // Register all tracking state and flags
    always_ff @(posedge Clk_i) begin
        if (!nReset_i) begin
            state_q  <= S0;
            valid_q  <= 1'b0;
            dwell_q  <= '0;
            armed_q  <= 1'b0;
            ipat_q   <= 1'b0;
            itrans_q <= 1'b0;
            short_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            dwell_q  <= dwell_d;
            armed_q  <= armed_d;
            ipat_q   <= ipat_d;
            itrans_q <= itrans_d;
            short_q  <= short_d;
        end
    end

`ifdef TRAFFIC_MON_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cyc_d, cyc_q;

    // Count completed rounds: an armed, legal S3 -> S0 change; wraps
    always_comb begin
        cyc_d = cyc_q;
        if (dec_valid && armed_q && (state_q == S3) && (dec_state == S0)) begin
            cyc_d = cyc_q + DWELL_ONE;
        end
    end

    // Round counter register
    always_ff @(posedge Clk_i) begin
        if (!nReset_i) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign CycleCnt_o = cyc_q;
`else
    assign CycleCnt_o = '0;
`endif

    assign State_o          = state_q;
    assign StateValid_o     = valid_q;
    assign DwellCnt_o       = dwell_q;
    assign IllegalPattern_o = ipat_q;
    assign IllegalTrans_o   = itrans_q;
    assign ShortDwell_o     = short_q;

endmodule
